// File: rtl/wb_stage_pipe_if.sv
// Bus between the MEM stage (master) and the write-back stage (slave).
// Carries the MEM-stage instruction fields and control into the stage, and
// the register-file write port, misalign flag and retire count back out.
interface wb_stage_pipe_if #(
   parameter int unsigned XLEN    = 32,
   parameter int unsigned RADDR_W = 5,
   parameter int unsigned CNT_W   = 64
);
   logic                valid_i;
   logic                stall_i;
   logic                flush_i;
   logic [1:0]          wb_ctrl_i;
   logic                link_i;
   logic [XLEN-1:0]     wb_data_i;
   logic [XLEN-1:0]     pc4_i;
   logic [XLEN-1:0]     data_i;
   logic [2:0]          ld_funct3_i;
   logic [1:0]          ld_addr_lo_i;
   logic [RADDR_W-1:0]  wb_Rd_i;

   logic [RADDR_W-1:0]  wb_Rd_o;
   logic                RegWrite_o;
   logic [XLEN-1:0]     w_data_o;
   logic                misalign_o;
   logic [CNT_W-1:0]    retired_o;

   // MEM stage side: drives instruction fields, observes the write port
   modport master (
      output valid_i, stall_i, flush_i, wb_ctrl_i, link_i, wb_data_i, pc4_i,
             data_i, ld_funct3_i, ld_addr_lo_i, wb_Rd_i,
      input  wb_Rd_o, RegWrite_o, w_data_o, misalign_o, retired_o
   );

   // Write-back stage side
   modport slave (
      input  valid_i, stall_i, flush_i, wb_ctrl_i, link_i, wb_data_i, pc4_i,
             data_i, ld_funct3_i, ld_addr_lo_i, wb_Rd_i,
      output wb_Rd_o, RegWrite_o, w_data_o, misalign_o, retired_o
   );
endinterface

// File: rtl/wb_stage_pipe.sv
// RV32 write-back stage: MEM/WB register plus write-back data select.
// Extracts and extends load bytes/halves, selects ALU / load / link data,
// drives the register-file write port, flags misaligned loads and counts
// retired instructions.
// Ports:
//   clk_i  - clock, all state on rising edge
//   rst_i  - asynchronous active-high reset
//   bus    - wb_stage_pipe_if.slave: MEM-stage fields in, RF write port out
module wb_stage_pipe #(
   parameter int unsigned XLEN       = 32,
   parameter int unsigned RADDR_W    = 5,
   parameter int unsigned CNT_W      = 64,
   parameter bit          X0_PROTECT = 1'b1
) (
   input  logic           clk_i,
   input  logic           rst_i,
   wb_stage_pipe_if.slave bus
);

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   logic [7:0]          ld_byte;
   logic [15:0]         ld_half;
   logic [XLEN-1:0]     ld_val;
   logic [XLEN-1:0]     sel_data;
   logic                is_half;
   logic                is_word;
   logic                mis_d;

   logic                valid_q;
   logic                regwrite_q;
   logic                mis_q;
   logic [RADDR_W-1:0]  rd_q;
   logic [XLEN-1:0]     data_q;
   logic [CNT_W-1:0]    retired_q;
   logic                rd_is_x0;
   logic                commit;

   // Load byte/half extraction and sign/zero extension
   always_comb begin
      ld_byte = bus.data_i[7:0];
      case (bus.ld_addr_lo_i)
         2'd1:    ld_byte = bus.data_i[15:8];
         2'd2:    ld_byte = bus.data_i[23:16];
         2'd3:    ld_byte = bus.data_i[31:24];
         default: ld_byte = bus.data_i[7:0];
      endcase
      ld_half = bus.ld_addr_lo_i[1] ? bus.data_i[31:16] : bus.data_i[15:0];
      case (bus.ld_funct3_i)
         F3_LB:   ld_val = {{(XLEN-8){ld_byte[7]}}, ld_byte};
         F3_LH:   ld_val = {{(XLEN-16){ld_half[15]}}, ld_half};
         F3_LBU:  ld_val = {{(XLEN-8){1'b0}}, ld_byte};
         F3_LHU:  ld_val = {{(XLEN-16){1'b0}}, ld_half};
         default: ld_val = bus.data_i;  // LW and unlisted encodings
      endcase
   end

   // Write-back select and misalign detection; link overrides the load path
   always_comb begin
      is_half = (bus.ld_funct3_i == F3_LH) || (bus.ld_funct3_i == F3_LHU);
      is_word = !is_half && (bus.ld_funct3_i != F3_LB) && (bus.ld_funct3_i != F3_LBU);
      mis_d   = bus.wb_ctrl_i[0] && !bus.link_i &&
                ((is_half && bus.ld_addr_lo_i[0]) || (is_word && (bus.ld_addr_lo_i != 2'd0)));
      if (bus.link_i)
         sel_data = bus.pc4_i;
      else if (bus.wb_ctrl_i[0])
         sel_data = ld_val;
      else
         sel_data = bus.wb_data_i;
   end

   // MEM/WB register: flush beats stall; fields load only for valid instrs so bubbles hold
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         valid_q    <= 1'b0;
         regwrite_q <= 1'b0;
         mis_q      <= 1'b0;
         rd_q       <= '0;
         data_q     <= '0;
      end else if (bus.flush_i) begin
         valid_q <= 1'b0;
      end else if (!bus.stall_i) begin
         valid_q <= bus.valid_i;
         if (bus.valid_i) begin
            regwrite_q <= bus.wb_ctrl_i[1];
            mis_q      <= mis_d;
            rd_q       <= bus.wb_Rd_i;
            data_q     <= sel_data;
         end
      end
   end

   // An instruction leaves the stage on its first unstalled cycle
   assign rd_is_x0 = X0_PROTECT && (rd_q == '0);
   assign commit   = valid_q && !bus.stall_i;

   // Retire counter, wraps silently
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)
         retired_q <= '0;
      else if (commit && !mis_q)
         retired_q <= retired_q + CNT_W'(1);
   end

   assign bus.RegWrite_o = commit && regwrite_q && !mis_q && !rd_is_x0;
   assign bus.misalign_o = commit && mis_q;
   assign bus.w_data_o   = data_q;
   assign bus.wb_Rd_o    = rd_q;
   assign bus.retired_o  = retired_q;

endmodule

// File: tb/tb_wb_stage_pipe.sv
// Directed bench for wb_stage_pipe with a scoreboard of expected write-backs.
module tb_wb_stage_pipe;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
      logic        we;
      logic        mis;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int              errors = 0;
   int              checks = 0;
   longint unsigned exp_ret = 0;
   exp_t            sb[$];

   wb_stage_pipe_if #(.XLEN(32), .RADDR_W(5), .CNT_W(64)) bus ();
   wb_stage_pipe_if #(.XLEN(32), .RADDR_W(5), .CNT_W(4))  bus4 ();

   wb_stage_pipe #(.XLEN(32), .RADDR_W(5), .CNT_W(64), .X0_PROTECT(1'b1)) dut (
      .clk_i(clk), .rst_i(rst), .bus(bus.slave));

   wb_stage_pipe #(.XLEN(32), .RADDR_W(5), .CNT_W(4), .X0_PROTECT(1'b1)) dut4 (
      .clk_i(clk), .rst_i(rst), .bus(bus4.slave));

   assign bus4.valid_i      = bus.valid_i;
   assign bus4.stall_i      = bus.stall_i;
   assign bus4.flush_i      = bus.flush_i;
   assign bus4.wb_ctrl_i    = bus.wb_ctrl_i;
   assign bus4.link_i       = bus.link_i;
   assign bus4.wb_data_i    = bus.wb_data_i;
   assign bus4.pc4_i        = bus.pc4_i;
   assign bus4.data_i       = bus.data_i;
   assign bus4.ld_funct3_i  = bus.ld_funct3_i;
   assign bus4.ld_addr_lo_i = bus.ld_addr_lo_i;
   assign bus4.wb_Rd_i      = bus.wb_Rd_i;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic exp_t mk(input logic [4:0] rd, input logic [31:0] data,
                               input logic we, input logic mis);
      exp_t e;
      e.rd = rd; e.data = data; e.we = we; e.mis = mis;
      return e;
   endfunction

   task automatic drv(input logic v, input logic st, input logic fl, input logic [1:0] ctrl,
                      input logic lk, input logic [31:0] wbd, input logic [31:0] pc4,
                      input logic [31:0] d, input logic [2:0] f3, input logic [1:0] a,
                      input logic [4:0] rd);
      bus.valid_i = v;   bus.stall_i = st;   bus.flush_i = fl;
      bus.wb_ctrl_i = ctrl; bus.link_i = lk; bus.wb_data_i = wbd;
      bus.pc4_i = pc4;   bus.data_i = d;     bus.ld_funct3_i = f3;
      bus.ld_addr_lo_i = a; bus.wb_Rd_i = rd;
   endtask

   // One cycle: check outputs at negedge, then update the scoreboard at the edge
   task automatic tick(input exp_t e);
      exp_t h;
      @(negedge clk);
      chk("retired", bus.retired_o, 64'(exp_ret));
      chk("retired4", 64'(bus4.retired_o), 64'(exp_ret) & 64'hF);
      if (sb.size() != 0 && !bus.stall_i) begin
         h = sb.pop_front();
         chk("regwrite", 64'(bus.RegWrite_o), 64'(h.we));
         chk("misalign", 64'(bus.misalign_o), 64'(h.mis));
         chk("w_data", 64'(bus.w_data_o), 64'(h.data));
         chk("wb_rd", 64'(bus.wb_Rd_o), 64'(h.rd));
         if (!h.mis) exp_ret++;
      end else begin
         chk("regwrite_idle", 64'(bus.RegWrite_o), 64'd0);
         chk("misalign_idle", 64'(bus.misalign_o), 64'd0);
      end
      @(posedge clk);
      if (bus.flush_i) begin
         if (bus.stall_i && sb.size() != 0) sb.delete();
      end else if (!bus.stall_i && bus.valid_i) begin
         sb.push_back(e);
      end
      #1;
   endtask

   task automatic alu(input logic [4:0] rd, input logic [31:0] val);
      drv(1'b1, 1'b0, 1'b0, 2'b10, 1'b0, val, 32'h0, 32'h0, 3'b010, 2'd0, rd);
      tick(mk(rd, val, rd != 5'd0, 1'b0));
   endtask

   task automatic ld(input logic [2:0] f3, input logic [1:0] a, input logic [4:0] rd,
                     input logic [31:0] expd, input logic mis);
      drv(1'b1, 1'b0, 1'b0, 2'b11, 1'b0, 32'hDEAD_BEEF, 32'h0, 32'h80FF_7F01, f3, a, rd);
      tick(mk(rd, expd, !mis, mis));
   endtask

   task automatic idle();
      drv(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 32'h0, 3'b000, 2'd0, 5'd0);
      tick(mk(5'd0, 32'h0, 1'b0, 1'b0));
   endtask

   initial begin
      drv(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 32'h0, 3'b000, 2'd0, 5'd0);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_regwrite", 64'(bus.RegWrite_o), 64'd0);
      chk("rst_w_data", 64'(bus.w_data_o), 64'd0);
      chk("rst_rd", 64'(bus.wb_Rd_o), 64'd0);
      chk("rst_misalign", 64'(bus.misalign_o), 64'd0);
      chk("rst_retired", bus.retired_o, 64'd0);
      rst = 1'b0;
      idle();
      idle();

      // ALU and link
      alu(5'd5, 32'h0000_1234);
      drv(1'b1, 1'b0, 1'b0, 2'b10, 1'b1, 32'hDEAD, 32'h0000_0104, 32'h0, 3'b010, 2'd0, 5'd6);
      tick(mk(5'd6, 32'h0000_0104, 1'b1, 1'b0));

      // Loads from 0x80FF7F01
      ld(3'b000, 2'd3, 5'd1,  32'hFFFF_FF80, 1'b0);
      ld(3'b100, 2'd1, 5'd2,  32'h0000_007F, 1'b0);
      ld(3'b001, 2'd2, 5'd4,  32'hFFFF_80FF, 1'b0);
      ld(3'b101, 2'd0, 5'd8,  32'h0000_7F01, 1'b0);
      ld(3'b010, 2'd0, 5'd11, 32'h80FF_7F01, 1'b0);
      ld(3'b111, 2'd0, 5'd10, 32'h80FF_7F01, 1'b0);

      // Misaligned loads: no write, no retire
      ld(3'b010, 2'd1, 5'd3,  32'h80FF_7F01, 1'b1);
      ld(3'b001, 2'd1, 5'd12, 32'h0000_7F01, 1'b1);

      // Link overrides MemToReg even with a misaligned address
      drv(1'b1, 1'b0, 1'b0, 2'b11, 1'b1, 32'h0, 32'h0000_0200, 32'h80FF_7F01, 3'b010, 2'd1, 5'd13);
      tick(mk(5'd13, 32'h0000_0200, 1'b1, 1'b0));

      // x0 destination: suppressed write, still retires
      alu(5'd0, 32'h0000_0055);
      idle();

      // Stall three cycles, then one write of the held instr
      alu(5'd7, 32'h0000_0777);
      repeat (3) begin
         drv(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0888, 32'h0, 32'h0, 3'b010, 2'd0, 5'd9);
         tick(mk(5'd9, 32'h0000_0888, 1'b1, 1'b0));
      end
      drv(1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 32'h0000_0888, 32'h0, 32'h0, 3'b010, 2'd0, 5'd9);
      tick(mk(5'd9, 32'h0000_0888, 1'b1, 1'b0));
      idle();

      // Stall + flush kills the held instr
      alu(5'd14, 32'h0000_000E);
      drv(1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 32'h0, 32'h0, 32'h0, 3'b000, 2'd0, 5'd0);
      tick(mk(5'd0, 32'h0, 1'b0, 1'b0));
      idle();
      idle();

      // Flush without stall: held instr writes, incoming one is killed
      alu(5'd15, 32'h0000_000F);
      drv(1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0BAD, 32'h0, 32'h0, 3'b010, 2'd0, 5'd16);
      tick(mk(5'd16, 32'h0000_0BAD, 1'b1, 1'b0));
      idle();

      // Reset mid-stall discards the held instr
      alu(5'd17, 32'h0000_0011);
      drv(1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 32'h0, 3'b000, 2'd0, 5'd0);
      tick(mk(5'd0, 32'h0, 1'b0, 1'b0));
      #2 rst = 1'b1;
      #1;
      chk("midrst_regwrite", 64'(bus.RegWrite_o), 64'd0);
      chk("midrst_w_data", 64'(bus.w_data_o), 64'd0);
      chk("midrst_rd", 64'(bus.wb_Rd_o), 64'd0);
      chk("midrst_retired", bus.retired_o, 64'd0);
      chk("midrst_retired4", 64'(bus4.retired_o), 64'd0);
      sb.delete();
      exp_ret = 0;
      rst = 1'b0;
      idle();
      idle();

      // Counter wrap on the 4-bit instance
      for (int i = 0; i < 17; i++) alu(5'(i + 1), 32'(i));
      idle();
      idle();
      chk("wrap_retired", bus.retired_o, 64'd17);
      chk("wrap_retired4", 64'(bus4.retired_o), 64'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
